// File: rtl/dbus_sram_responder.sv
// dbus responder: 64-bit single-port scratchpad, fixed latency.
// Ports: clk, resetn, dreq/dresp bus, err pulse, dbg backdoor read.
package dbus_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  dbus_req_t                dreq,
  output dbus_resp_t               dresp,
  output logic                     err,
  input  logic [$clog2(DEPTH)-1:0] dbg_idx,
  output logic [63:0]              dbg_word
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [7:0]  strb_q, strb_d;
  logic [63:0] wdat_q, wdat_d;
  logic        fault_q, fault_d;
  logic [AW-1:0] idx_q, idx_d;
  dbus_resp_t  resp_q, resp_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];

  // The request being resolved: live bus when firing straight
  // out of IDLE (LATENCY==1), else the captured copy.
  logic [63:0]   cur_addr;
  msize_t        cur_size;
  logic [7:0]    cur_strb;
  logic [63:0]   off;
  logic          in_rng;
  logic          misal;
  logic          fault;
  logic [AW-1:0] cur_idx;
  logic          fire;

  always_comb begin
    cur_addr = addr_q;
    cur_size = size_q;
    cur_strb = strb_q;
    if (state_q == IDLE) begin
      cur_addr = dreq.addr;
      cur_size = dreq.size;
      cur_strb = dreq.strobe;
    end
    off    = cur_addr - BASE_ADDR;
    in_rng = (cur_addr >= BASE_ADDR) &&
             (off[63:AW+3] == '0);
    // BASE_ADDR is word aligned, so off[2:0]==addr[2:0].
    misal = 1'b0;
    unique case (cur_size)
      MSIZE1: misal = 1'b0;
      MSIZE2: misal = off[0];
      MSIZE4: misal = |off[1:0];
      MSIZE8: misal = |off[2:0];
      default: misal = 1'b1;
    endcase
    fault   = !in_rng || misal;
    cur_idx = off[AW+2:3];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    strb_d  = strb_q;
    wdat_d  = wdat_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    resp_d  = '0;
    err_d   = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          addr_d = dreq.addr;
          size_d = dreq.size;
          strb_d = dreq.strobe;
          wdat_d = dreq.data;
          cnt_d  = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = RESP;
            fire    = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response is registered on the edge entering RESP.
    if (fire) begin
      resp_d.addr_ok = 1'b1;
      resp_d.data_ok = 1'b1;
      if (!fault && cur_strb == 8'h00) begin
        resp_d.data = mem_q[cur_idx];
      end
      err_d   = fault;
      fault_d = fault;
      idx_d   = cur_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= MSIZE1;
      strb_q  <= '0;
      wdat_q  <= '0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      strb_q  <= strb_d;
      wdat_q  <= wdat_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Write commits on the edge leaving RESP; a reset held
  // across that edge keeps state out of RESP and drops it.
  always_ff @(posedge clk) begin
    if (state_q == RESP && !fault_q) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
        end
      end
    end
  end

  assign dresp    = resp_q;
  assign err      = err_q;
  assign dbg_word = mem_q[dbg_idx];
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: random + directed requests
// checked every cycle against a word-array reference model.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       resetn;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;
  logic [$clog2(DEPTH)-1:0] dbg_idx;
  logic [63:0] dbg_word;

  dbus_sram_responder #(
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .dreq(dreq),
    .dresp(dresp),
    .err(err),
    .dbg_idx(dbg_idx),
    .dbg_word(dbg_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  logic [63:0] mdl [DEPTH];

  function automatic bit is_fault(logic [63:0] a, msize_t s);
    logic [63:0] nb;
    nb = 64'(1) << int'(s);
    if (a < BASE || a >= BASE + 64'(DEPTH * 8)) return 1'b1;
    return (a % nb) != 64'd0;
  endfunction

  function automatic int idx_of(logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Every cycle: outputs are zero unless a response is due now.
  always @(negedge clk) begin
    dbus_resp_t ew;
    logic ee;
    exp_t r;
    int i;
    if (chk_en) begin
      ew = '0;
      ee = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        r = q.pop_front();
        ew.addr_ok = 1'b1;
        ew.data_ok = 1'b1;
        ee = is_fault(r.addr, r.size);
        if (!ee) begin
          i = idx_of(r.addr);
          if (r.strobe == 8'h00) begin
            ew.data = mdl[i];
          end else begin
            for (int b = 0; b < 8; b++)
              if (r.strobe[b]) mdl[i][8*b +: 8] = r.data[8*b +: 8];
          end
        end
      end
      total++;
      if (dresp !== ew || err !== ee) begin
        bad++;
        $display("FAIL resp cyc=%0d got ok=%b%b data=%h err=%b want ok=%b%b data=%h err=%b",
                 cyc, dresp.addr_ok, dresp.data_ok, dresp.data, err,
                 ew.addr_ok, ew.data_ok, ew.data, ee);
      end
    end
  end

  task automatic do_req(input logic [63:0] a, input msize_t s,
                        input logic [7:0] st, input logic [63:0] d,
                        output logic [63:0] rd, output logic re);
    exp_t e;
    bit got;
    @(negedge clk);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = s;
    dreq.strobe = st;
    dreq.data   = d;
    e.cyc = cyc + LAT;
    e.addr = a;
    e.size = s;
    e.strobe = st;
    e.data = d;
    q.push_back(e);
    got = 1'b0;
    rd = '0;
    re = 1'b0;
    for (int k = 0; k < LAT + 8 && !got; k++) begin
      @(negedge clk);
      if (dresp.data_ok) begin
        got = 1'b1;
        rd = dresp.data;
        re = err;
      end
    end
    dreq = '0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout addr=%h got no data_ok want one within %0d cycles",
               a, LAT + 8);
    end
    @(negedge clk);
  endtask

  task automatic scan(string nm);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_idx = ($clog2(DEPTH))'(i);
      #1;
      chk(nm, dbg_word, mdl[i]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, a, sav, nd;
    logic re;
    msize_t s;
    logic [7:0] st;
    int sel, t0;
    int pulses[$];

    resetn = 1'b0;
    dreq = '0;
    dbg_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", 64'({dresp.addr_ok, dresp.data_ok, err}), 64'd0);
    chk("rst_data", dresp.data, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      nd = {$urandom, $urandom};
      mdl[i] = 'x;
      do_req(BASE + 64'(8 * i), MSIZE8, 8'hFF, nd, rd, re);
    end
    scan("fill");

    do_req(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, rd, re);
    dbg_idx = 2;
    #1;
    chk("sd_dbg", dbg_word, 64'h1122_3344_5566_7788);
    do_req(64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, re);
    chk("ld_data", rd, 64'h1122_3344_5566_7788);
    chk("ld_err", 64'(re), 64'd0);

    do_req(64'h8000_0012, MSIZE1, 8'h04, 64'h0000_0000_00AB_0000, rd, re);
    dbg_idx = 2;
    #1;
    chk("sb_dbg", dbg_word, 64'h1122_3344_55AB_7788);

    do_req(64'h8000_0006, MSIZE4, 8'h00, 64'd0, rd, re);
    chk("mis_data", rd, 64'd0);
    chk("mis_err", 64'(re), 64'd1);
    scan("mis_scan");

    do_req(64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, re);
    chk("oor_err", 64'(re), 64'd1);
    scan("oor_scan");

    // Back-to-back reads, valid held across both.
    @(negedge clk);
    t0 = cyc;
    dreq.valid = 1'b1;
    dreq.addr = BASE + 64'h18;
    dreq.size = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data = '0;
    q.push_back('{t0 + LAT, BASE + 64'h18, MSIZE8, 8'h00, 64'd0});
    q.push_back('{t0 + 2 * LAT + 1, BASE + 64'h20, MSIZE8, 8'h00, 64'd0});
    for (int k = 0; k < 3 * LAT + 4; k++) begin
      @(negedge clk);
      if (dresp.data_ok) pulses.push_back(cyc - t0);
      if (cyc == t0 + LAT) dreq.addr = BASE + 64'h20;
      if (cyc == t0 + 2 * LAT + 1) dreq = '0;
    end
    chk("b2b_count", 64'(pulses.size()), 64'd2);
    if (pulses.size() == 2) begin
      chk("b2b_first", 64'(pulses[0]), 64'd2);
      chk("b2b_gap", 64'(pulses[1] - pulses[0]), 64'd3);
    end

    for (int n = 0; n < 300; n++) begin
      s = msize_t'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0)
        a = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
      else if (sel == 1)
        a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 63));
      else
        a = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
      if ($urandom_range(0, 3) != 0)
        a = a & ~(64'((1 << int'(s)) - 1));
      st = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      do_req(a, s, st, {$urandom, $urandom}, rd, re);
    end
    scan("rand_scan");

    // Reset during WAIT of a store: dropped, then normal service.
    chk_en = 1'b0;
    sav = mdl[5];
    @(negedge clk);
    dreq.valid = 1'b1;
    dreq.addr = BASE + 64'h28;
    dreq.size = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data = ~sav;
    @(negedge clk);
    resetn = 1'b0;
    dreq = '0;
    #1;
    chk("rstw_flags", 64'({dresp.addr_ok, dresp.data_ok, err}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    dbg_idx = 5;
    #1;
    chk("rstw_word", dbg_word, sav);
    @(negedge clk);
    chk_en = 1'b1;
    nd = 64'h0123_4567_89AB_CDEF;
    do_req(BASE + 64'h28, MSIZE8, 8'hFF, nd, rd, re);
    do_req(BASE + 64'h28, MSIZE8, 8'h00, 64'd0, rd, re);
    chk("rstw_after", rd, nd);

    // Reset while a store response is on the bus.
    chk_en = 1'b0;
    sav = mdl[7];
    @(negedge clk);
    dreq.valid = 1'b1;
    dreq.addr = BASE + 64'h38;
    dreq.size = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data = ~sav;
    for (int k = 0; k < LAT + 8 && !dresp.data_ok; k++)
      @(negedge clk);
    chk("rstr_seen", 64'(dresp.data_ok), 64'd1);
    resetn = 1'b0;
    dreq = '0;
    #1;
    chk("rstr_flags", 64'({dresp.addr_ok, dresp.data_ok, err}), 64'd0);
    chk("rstr_data", dresp.data, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    dbg_idx = 7;
    #1;
    chk("rstr_word", dbg_word, sav);
    @(negedge clk);
    chk_en = 1'b1;
    do_req(BASE + 64'h38, MSIZE8, 8'h00, 64'd0, rd, re);
    scan("final_scan");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Responder end of the data-bus (dbus) request/response interface; the pipeline memory stage is the initiator.
- Models a single-port 64-bit-wide data scratchpad with a configurable fixed access latency, byte-strobe writes and full-lane reads.
- Sits behind the memory stage in simulation tops and unit benches.
- The initiator does the lane extraction and sign extension on reads and the lane placement on writes; this block does neither.

Parameters:
- DEPTH, 1024, number of 64-bit words; power of two, at least 2.
- LATENCY, 2, cycles from request acceptance to response; at least 1.
- BASE_ADDR, 64'h8000_0000, byte address of word 0; aligned to DEPTH*8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  request: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data.
- err  output  1  one-cycle pulse on a faulted response.
- dbg_idx  input  log2(DEPTH)  bench backdoor word index.
- dbg_word  output  64  combinational read of mem[dbg_idx].

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (resetn low, asynchronous):
  - State goes to IDLE, the latency counter to 0 and the captured request to 0.
  - dresp.addr_ok, dresp.data_ok, dresp.data and err all read 0.
  - Memory contents are not reset.
- IDLE:
  - If dreq.valid is high at edge T, capture addr, size, strobe and data.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1, otherwise to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP when the counter reaches 0.
  - If dreq.valid drops, abort to IDLE with no write and no response. This is a protocol violation; the bench also flags it.
- RESP (exactly one cycle, cycle T+LATENCY):
  - dresp.addr_ok and dresp.data_ok are both 1; all response outputs are registered.
  - Next state is IDLE. A request still valid in the following cycle is treated as a new request, so back-to-back requests are spaced LATENCY+1 cycles apart.
- Decode:
  - off = addr - BASE_ADDR.
  - In range iff addr >= BASE_ADDR and off < DEPTH*8.
  - Word index = off[log2(DEPTH)+2:3].
- Alignment requirements:
  - MSIZE1: any address.
  - MSIZE2: addr[0]==0.
  - MSIZE4: addr[1:0]==0.
  - MSIZE8: addr[2:0]==0.
- Fault = out of range or misaligned. On a fault:
  - The memory is not written.
  - dresp.data is 0.
  - err is 1 in the RESP cycle.
  - The handshake still completes, so the initiator never hangs.
- Read (strobe==0, no fault): dresp.data is the full 64-bit word at the index, sampled in the RESP cycle.
- Write (strobe!=0, no fault):
  - In the RESP cycle edge, for each byte b with strobe[b]==1, mem[idx][8b+7:8b] takes data[8b+7:8b]. Other bytes are unchanged.
  - dresp.data is 0.
  - The strobe is applied as given; its consistency with size is not checked.
- Hazards:
  - A read issued after a write to the same word returns the written value, because the write commits before the read is accepted.
  - dbg_word reflects a write on the cycle after the RESP edge.
- Outputs are 0 in every cycle other than RESP.
- Reset asserted during WAIT or RESP: the pending write is dropped and outputs go to 0 immediately (asynchronously).

Test Plan:
- LATENCY=2: SD to 0x8000_0010 with data 0x1122_3344_5566_7788, strobe 0xFF, request held. data_ok goes high exactly 2 cycles after acceptance; dbg_idx=2 then shows 0x1122334455667788. A following LD to the same address returns the same word in dresp.data with err=0.
- SB: write data 0x0000_0000_00AB_0000 with strobe 0x04 to 0x8000_0012, over the word above. The word becomes 0x1122_3344_55AB_7788; only byte 2 changes.
- Misaligned MSIZE4 read at 0x8000_0006. Response arrives on schedule with dresp.data=0, err=1, and the memory is unchanged.
- Out-of-range MSIZE8 write to 0x7FFF_FFF8 with strobe 0xFF. Response arrives with err=1; a dbg scan shows no word modified.
- Two back-to-back reads with valid held continuously. The data_ok pulses are exactly LATENCY+1 cycles apart, each one cycle wide.
- Assert resetn low during WAIT of an SD. Outputs go to 0 immediately, the target word is unchanged, and after release the state is IDLE and the next request completes normally.
